// File: rtl/tlc_light_monitor_pkg.sv
// Shared light package: signal-head colour type, head indices, allowed
// non-red sets and the monitor's fault codes.
// Ports: none (package).
package tlc_light_monitor_pkg;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    YELLOW = 2'd1,
    GREEN  = 2'd2
  } colors;

  typedef enum logic [2:0] {
    FC_NONE      = 3'd0,
    FC_CONFLICT  = 3'd1,
    FC_ILLEGAL   = 3'd2,
    FC_YEL_LEN   = 3'd3,
    FC_CLEARANCE = 3'd4,
    FC_ENCODING  = 3'd5
  } fault_code_e;

  localparam int NUM_HEADS = 5;
  localparam int ES = 0;
  localparam int WS = 1;
  localparam int EL = 2;
  localparam int WL = 3;
  localparam int NS = 4;

  localparam logic [4:0] SET_ES_WS = 5'b00011;
  localparam logic [4:0] SET_ES_EL = 5'b00101;
  localparam logic [4:0] SET_WS_WL = 5'b01010;
  localparam logic [4:0] SET_EL_WL = 5'b01100;
  localparam logic [4:0] SET_NS    = 5'b10000;

  // A set of non-red heads is safe when it fits inside one allowed set.
  function automatic logic is_allowed(input logic [4:0] mask);
    return ((mask & ~SET_ES_WS) == 5'b0) || ((mask & ~SET_ES_EL) == 5'b0) ||
           ((mask & ~SET_WS_WL) == 5'b0) || ((mask & ~SET_EL_WL) == 5'b0) ||
           ((mask & ~SET_NS)    == 5'b0);
  endfunction

endpackage

// File: rtl/tlc_light_monitor_if.sv
// Bundle between the controller side (master) and the safety monitor (slave).
// Master drives the five heads and clr_fault; slave returns fault status.
// Ports: e/w_str_light, e/w_left_light, ns_light, clr_fault, fault, fault_code, fault_heads, viol_cnt.
interface tlc_light_monitor_if #(parameter int CNT_W = 8);
  import tlc_light_monitor_pkg::*;

  colors             e_str_light;
  colors             w_str_light;
  colors             e_left_light;
  colors             w_left_light;
  colors             ns_light;
  logic              clr_fault;
  logic              fault;
  logic [2:0]        fault_code;
  logic [4:0]        fault_heads;
  logic [CNT_W-1:0]  viol_cnt;

  modport master (
    output e_str_light, w_str_light, e_left_light, w_left_light, ns_light, clr_fault,
    input  fault, fault_code, fault_heads, viol_cnt
  );

  modport slave (
    input  e_str_light, w_str_light, e_left_light, w_left_light, ns_light, clr_fault,
    output fault, fault_code, fault_heads, viol_cnt
  );

endinterface

// File: rtl/tlc_light_monitor_head_tracker.sv
// Per-head history: previous colour and consecutive-yellow count, with flags.
// Latency: flags are combinational from the current sample and the history.
// Backpressure: none; samples every cycle.
// Ports: clk, reset, cur (head colour) -> enc_bad, non_red, illegal, yel_len, new_green.
module tlc_head_tracker
  import tlc_light_monitor_pkg::*;
#(
  parameter int YEL_CYCLES = 2
) (
  input  logic  clk,
  input  logic  reset,
  input  colors cur,
  output logic  enc_bad,
  output logic  non_red,
  output logic  illegal,
  output logic  yel_len,
  output logic  new_green
);

  localparam int YW = $clog2(YEL_CYCLES + 2);
  localparam logic [YW-1:0] Y_LIM = YW'(YEL_CYCLES);
  localparam logic [YW-1:0] Y_SAT = YW'(YEL_CYCLES + 1);

  colors          prev;
  colors          eff;
  logic [YW-1:0]  ycnt;

  always_comb begin
    enc_bad   = (cur != RED) && (cur != YELLOW) && (cur != GREEN);
    // An undecodable head is tracked as red so history stays well-formed.
    eff       = enc_bad ? RED : cur;
    non_red   = (eff != RED);
    illegal   = ((prev == RED)    && (eff == YELLOW)) ||
                ((prev == YELLOW) && (eff == GREEN))  ||
                ((prev == GREEN)  && (eff == RED));
    // ycnt counts yellows before this sample: overrun or a run cut short.
    yel_len   = ((eff == YELLOW) && (ycnt == Y_LIM)) ||
                ((prev == YELLOW) && (eff == RED) && (ycnt < Y_LIM));
    new_green = (prev == RED) && (eff == GREEN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev <= RED;
      ycnt <= '0;
    end else begin
      prev <= eff;
      if (eff != YELLOW)    ycnt <= '0;
      else if (ycnt != Y_SAT) ycnt <= ycnt + 1'b1;
    end
  end

endmodule

// File: rtl/tlc_light_monitor.sv
// Safety monitor for the five signal heads; sticky fault forces flashing red.
// Latency: one cycle from sampled heads to registered fault outputs.
// Backpressure: none; observes every cycle, never stalls the controller.
// Ports: clk, reset, mon (slave: heads + clr_fault in, fault/fault_code/fault_heads/viol_cnt out).
module tlc_light_monitor
  import tlc_light_monitor_pkg::*;
#(
  parameter int YEL_CYCLES = 2,
  parameter int ALLRED_MIN = 1,
  parameter int CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  tlc_light_monitor_if.slave   mon
);

  localparam logic [3:0] AR_MIN = 4'(ALLRED_MIN);

  colors       heads [NUM_HEADS];
  logic [4:0]  enc_bad, non_red, illegal, yel_len, new_green;
  logic        conflict, all_red, ar_ok, any_viol;
  logic [4:0]  clr_mask;
  fault_code_e win_code;
  logic [4:0]  win_mask;

  logic [3:0]        arcnt;
  logic              fault_q;
  fault_code_e       code_q;
  logic [4:0]        heads_q;
  logic [CNT_W-1:0]  cnt_q;

  assign heads[ES] = mon.e_str_light;
  assign heads[WS] = mon.w_str_light;
  assign heads[EL] = mon.e_left_light;
  assign heads[WL] = mon.w_left_light;
  assign heads[NS] = mon.ns_light;

  for (genvar i = 0; i < NUM_HEADS; i++) begin : g_head
    tlc_head_tracker #(.YEL_CYCLES(YEL_CYCLES)) u_trk (
      .clk       (clk),
      .reset     (reset),
      .cur       (heads[i]),
      .enc_bad   (enc_bad[i]),
      .non_red   (non_red[i]),
      .illegal   (illegal[i]),
      .yel_len   (yel_len[i]),
      .new_green (new_green[i])
    );
  end

  always_comb begin
    conflict = !is_allowed(non_red);
    all_red  = (non_red == 5'b0);
    // arcnt != 0 means the previous sample was all red, even if ALLRED_MIN is 0.
    ar_ok    = (arcnt != 4'd0) && (arcnt >= AR_MIN);
    clr_mask = ar_ok ? 5'b0 : new_green;

    win_code = FC_NONE;
    win_mask = 5'b0;
    if (|enc_bad) begin
      win_code = FC_ENCODING;  win_mask = enc_bad;
    end else if (conflict) begin
      win_code = FC_CONFLICT;  win_mask = non_red;
    end else if (|illegal) begin
      win_code = FC_ILLEGAL;   win_mask = illegal;
    end else if (|yel_len) begin
      win_code = FC_YEL_LEN;   win_mask = yel_len;
    end else if (|clr_mask) begin
      win_code = FC_CLEARANCE; win_mask = clr_mask;
    end
    any_viol = (win_code != FC_NONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      arcnt   <= 4'd0;
      fault_q <= 1'b0;
      code_q  <= FC_NONE;
      heads_q <= 5'b0;
      cnt_q   <= '0;
    end else begin
      if (!all_red)             arcnt <= 4'd0;
      else if (arcnt != 4'd15)  arcnt <= arcnt + 4'd1;

      if (any_viol && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;

      // Only the first violation is captured; a clear needs a clean all-red cycle.
      if (any_viol) begin
        if (!fault_q) begin
          fault_q <= 1'b1;
          code_q  <= win_code;
          heads_q <= win_mask;
        end
      end else if (mon.clr_fault && all_red) begin
        fault_q <= 1'b0;
        code_q  <= FC_NONE;
        heads_q <= 5'b0;
      end
    end
  end

  assign mon.fault       = fault_q;
  assign mon.fault_code  = code_q;
  assign mon.fault_heads = heads_q;
  assign mon.viol_cnt    = cnt_q;

endmodule

// File: tb/tb_tlc_light_monitor.sv
// Directed bench for tlc_light_monitor: two instances (ALLRED_MIN 1 and 2)
// driven with identical head sequences; expectations are hand-computed.
module tb_tlc_light_monitor;
  import tlc_light_monitor_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  tlc_light_monitor_if #(.CNT_W(8)) bus1 ();
  tlc_light_monitor_if #(.CNT_W(8)) bus2 ();

  tlc_light_monitor #(.YEL_CYCLES(2), .ALLRED_MIN(1), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .mon(bus1.slave)
  );
  tlc_light_monitor #(.YEL_CYCLES(2), .ALLRED_MIN(2), .CNT_W(8)) dut2 (
    .clk(clk), .reset(reset), .mon(bus2.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge and are sampled at the next.
  task automatic step(input colors es, input colors ws, input colors el,
                      input colors wl, input colors ns, input logic clr = 1'b0);
    bus1.e_str_light = es; bus1.w_str_light = ws; bus1.e_left_light = el;
    bus1.w_left_light = wl; bus1.ns_light = ns; bus1.clr_fault = clr;
    bus2.e_str_light = es; bus2.w_str_light = ws; bus2.e_left_light = el;
    bus2.w_left_light = wl; bus2.ns_light = ns; bus2.clr_fault = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    step(RED, RED, RED, RED, RED);
    reset = 1'b0;
  endtask

  task automatic chk1(input string tag, input logic f, input logic [2:0] code,
                      input logic [4:0] hd, input logic [7:0] cnt);
    chk({tag, "_fault"}, bus1.fault, f);
    chk({tag, "_code"},  bus1.fault_code, code);
    chk({tag, "_heads"}, bus1.fault_heads, hd);
    chk({tag, "_cnt"},   bus1.viol_cnt, cnt);
  endtask

  initial begin
    colors bad;
    bad = colors'(2'b11);

    // Reset state
    do_reset();
    reset = 1'b1;
    step(RED, RED, RED, RED, RED);
    chk1("reset", 1'b0, 3'd0, 5'b0, 8'd0);
    reset = 1'b0;

    // Legal sequence: all red, ES+WS green x5, yellow x2, red, ES+EL green x3
    step(RED, RED, RED, RED, RED);
    chk("legal", {bus1.fault, bus1.viol_cnt}, 0);
    for (int i = 0; i < 5; i++) begin
      step(GREEN, GREEN, RED, RED, RED);
      chk("legal_g", {bus1.fault, bus1.viol_cnt}, 0);
    end
    for (int i = 0; i < 2; i++) begin
      step(YELLOW, YELLOW, RED, RED, RED);
      chk("legal_y", {bus1.fault, bus1.viol_cnt}, 0);
    end
    step(RED, RED, RED, RED, RED);
    chk("legal_r", {bus1.fault, bus1.viol_cnt}, 0);
    for (int i = 0; i < 3; i++) begin
      step(GREEN, RED, GREEN, RED, RED);
      chk("legal_g2", {bus1.fault, bus1.viol_cnt}, 0);
    end

    // Conflict ES+WL (EL green->red and WL clearance also present, conflict wins)
    step(GREEN, RED, RED, GREEN, RED);
    chk1("conflict", 1'b1, 3'd1, 5'b01001, 8'd1);

    // Yellow too long on NS, then clear behaviour
    do_reset();
    step(RED, RED, RED, RED, RED);
    step(RED, RED, RED, RED, NS == 4 ? GREEN : RED);
    step(RED, RED, RED, RED, YELLOW);
    step(RED, RED, RED, RED, YELLOW);
    chk("yel_two_ok", bus1.fault, 1'b0);
    step(RED, RED, RED, RED, YELLOW);
    chk1("yel_long", 1'b1, 3'd3, 5'b10000, 8'd1);
    step(RED, RED, RED, RED, YELLOW);
    chk("yel_sat_cnt", bus1.viol_cnt, 8'd1);
    step(RED, RED, RED, RED, RED);
    chk("yel_end_cnt", bus1.viol_cnt, 8'd1);
    step(RED, RED, RED, RED, GREEN, 1'b1);
    chk1("clr_ignored", 1'b1, 3'd3, 5'b10000, 8'd1);
    step(RED, RED, RED, RED, YELLOW);
    step(RED, RED, RED, RED, YELLOW);
    step(RED, RED, RED, RED, RED, 1'b1);
    chk1("clr_done", 1'b0, 3'd0, 5'b0, 8'd1);
    step(RED, RED, RED, RED, YELLOW, 1'b1);
    chk1("clr_new_viol", 1'b1, 3'd2, 5'b10000, 8'd2);
    step(RED, RED, RED, RED, RED, 1'b1);
    chk1("clr_blocked", 1'b1, 3'd2, 5'b10000, 8'd3);

    // Illegal transition EL+WL green -> red
    do_reset();
    step(RED, RED, RED, RED, RED);
    step(RED, RED, GREEN, GREEN, RED);
    step(RED, RED, GREEN, GREEN, RED);
    chk("ill_pre", bus1.fault, 1'b0);
    step(RED, RED, RED, RED, RED);
    chk1("illegal", 1'b1, 3'd2, 5'b01100, 8'd1);

    // Clearance: only one all-red cycle before green; fails ALLRED_MIN=2 only
    do_reset();
    step(RED, RED, RED, RED, RED);
    step(RED, RED, RED, RED, RED);
    step(GREEN, GREEN, RED, RED, RED);
    step(GREEN, GREEN, RED, RED, RED);
    step(YELLOW, YELLOW, RED, RED, RED);
    step(YELLOW, YELLOW, RED, RED, RED);
    step(RED, RED, RED, RED, RED);
    chk("clear_pre2", bus2.fault, 1'b0);
    step(GREEN, GREEN, RED, RED, RED);
    chk("clear2_fault", bus2.fault, 1'b1);
    chk("clear2_code", bus2.fault_code, 3'd4);
    chk("clear2_heads", bus2.fault_heads, 5'b00011);
    chk("clear1_ok", bus1.fault, 1'b0);

    // Bad encoding beats a simultaneous conflict
    do_reset();
    step(RED, RED, RED, RED, RED);
    step(bad, RED, RED, GREEN, GREEN);
    chk1("encoding", 1'b1, 3'd5, 5'b00001, 8'd1);

    // Counter saturation over 300 conflict cycles
    do_reset();
    step(RED, RED, RED, RED, RED);
    for (int i = 0; i < 254; i++) step(GREEN, RED, RED, GREEN, RED);
    chk("sat_254", bus1.viol_cnt, 8'd254);
    step(GREEN, RED, RED, GREEN, RED);
    chk("sat_255", bus1.viol_cnt, 8'd255);
    for (int i = 0; i < 45; i++) step(GREEN, RED, RED, GREEN, RED);
    chk1("sat_300", 1'b1, 3'd1, 5'b01001, 8'd255);

    // Reset asserted mid-fault clears everything in one edge
    reset = 1'b1;
    step(GREEN, RED, RED, GREEN, RED);
    chk1("reset_mid", 1'b0, 3'd0, 5'b0, 8'd0);
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/tlc_light_monitor.md
# tlc_light_monitor

Independent safety monitor that consumes the five signal-head outputs (`colors` type) of the three-street traffic light controller and checks every cycle that the displayed aspects are legal. It detects conflicting greens or yellows, illegal aspect transitions, wrong yellow durations and missing all-red clearance. It raises a sticky fault that the top level uses to force all heads to flashing red. It sits alongside the controller on the same clock and reset and has no influence on the controller's state.

## Interface
- `YEL_CYCLES`, 2: required length of every yellow run, in cycles.
- `ALLRED_MIN`, 1: minimum consecutive all-red cycles before any head may turn green.
- `CNT_W`, 8: width of the violation counter.

- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `e_str_light`, `w_str_light`, `e_left_light`, `w_left_light`, `ns_light`  in  `colors`  heads under watch. Bit order for masks is ES=0, WS=1, EL=2, WL=3, NS=4.
- `clr_fault`  in  1  request to clear the sticky fault.
- `fault`  out  1  sticky fault; also serves as the flash-red request.
- `fault_code`  out  3  code of the first captured fault: 0 none, 1 conflict, 2 illegal transition, 3 yellow length, 4 clearance, 5 bad encoding.
- `fault_heads`  out  5  mask of the heads involved in the captured fault.
- `viol_cnt`  out  `CNT_W`  count of cycles containing at least one violation; saturating.

## Operation
- **Allowed non-red sets:** any subset of {ES,WS}, {ES,EL}, {WS,WL}, {EL,WL}, {NS}. Any other combination of non-red heads (yellow or green) is a conflict. The mask holds all non-red heads.
- **Per-head history:** `prev` color (reset: red) and `ycnt` (reset: 0). `ycnt` counts consecutive yellow cycles and saturates at `YEL_CYCLES`+1.
- **Legal transitions:** red→red, red→green, green→green, green→yellow, yellow→yellow, yellow→red.
- **Illegal transitions:** red→yellow, yellow→green, green→red. The mask holds the offending heads.
- **Yellow length:** there are two violations.
  - A head is yellow with `ycnt` already equal to `YEL_CYCLES`.
  - A head goes yellow→red with `ycnt` < `YEL_CYCLES`.
- **Clearance:**
  - `arcnt` counts consecutive all-red samples. It saturates at 15 and resets to 0.
  - A red→green is legal only if the previous sample was all red and `arcnt` ≥ `ALLRED_MIN`.
  - Several heads turning green in the same cycle is legal.
- **Bad encoding:** any head value that is not red, yellow or green. Such a head is treated as red for history purposes.
- **Simultaneous violations:** priority is encoding > conflict > illegal transition > yellow length > clearance. Only the winner is captured. `fault_heads` is the winner's mask.
- **Sticky fault:**
  - The first violation sets `fault` and captures `fault_code` and `fault_heads`.
  - Later violations only increment `viol_cnt`.
  - `clr_fault` clears `fault`, `fault_code` and `fault_heads` only in a cycle where all heads sample red and no violation is present. Otherwise it is ignored.
- History registers keep updating while faulted.

## Timing
- All outputs are registered.
- A violation in the inputs sampled at edge *n* appears on the outputs after edge *n*, i.e. one cycle of latency.
- **Reset values:** `fault`=0, `fault_code`=0, `fault_heads`=0, `viol_cnt`=0, all `prev`=red, `ycnt`=0, `arcnt`=0.
- Reset asserted mid-fault clears everything within the same edge.
- The controller's first post-reset output is all red, so `arcnt` reaches 1 before any green; no false clearance fault occurs with `ALLRED_MIN`=1.
- `viol_cnt` holds at 2^`CNT_W`−1.
- A `clr_fault` in the same cycle as a new violation does not clear. That violation is counted but not captured.

## Structure
- Add the following to the shared light package:
  - the fault-code enum;
  - head index constants ES/WS/EL/WL/NS;
  - the five allowed-set masks as constants.
- `colors` is imported from the same package.
- Sub-module `tlc_head_tracker` holds one head's `prev` color and `ycnt`. It outputs that head's illegal-transition, yellow-length and new-green flags. Five instances are used.
- The top level computes conflict, clearance, priority and the sticky capture.

## Test plan
- **Legal sequence passes:**
  - Stimulus: reset; 1 cycle all red; ES+WS green ×5; yellow ×2; all red ×1; ES+EL green ×3.
  - Required response: `fault`=0 and `viol_cnt`=0 throughout.
- **Conflict:**
  - Stimulus: ES green with WL green for one cycle.
  - Required response: next cycle `fault`=1, `fault_code`=1, `fault_heads`=5'b01001, `viol_cnt`=1.
- **Yellow too long:**
  - Stimulus: NS yellow for 3 cycles.
  - Required response: on the sample of the third yellow, `fault_code`=3, `fault_heads`=5'b10000.
- **Illegal transition:**
  - Stimulus: EL+WL green→red directly.
  - Required response: `fault_code`=2, `fault_heads`=5'b01100.
- **Clearance:**
  - Stimulus: `ALLRED_MIN`=2; yellow ×2; red ×1; ES+WS green.
  - Required response: `fault_code`=4, `fault_heads`=5'b00011.
- **Clear and saturation:**
  - Stimulus: `clr_fault` while NS is green.
  - Required response: ignored.
  - Stimulus: `clr_fault` during all red.
  - Required response: `fault`=0, `fault_code`=0.
  - Stimulus: 300 conflict cycles with `CNT_W`=8.
  - Required response: `viol_cnt`=255.
